// File: rtl/ball_pocket_tracker.sv
// Per-frame ball-over-hole overlap accumulator feeding the game controller.
// Counts overlap pixels per ball during a frame and reports pockets one cycle after startOfFrame.
module ball_pocket_tracker #(
  parameter int NUM_BALLS   = 3,
  parameter int NUM_HOLES   = 6,
  parameter int OVERLAP_MIN = 64,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 rack,
  input  logic [NUM_BALLS:0]   ball_draw_req,
  input  logic [NUM_HOLES-1:0] hole_draw_req,
  output logic [NUM_BALLS:0]   balls_in_game,
  output logic [NUM_BALLS:0]   ballhole_collide,
  output logic [2:0]           curr_Hole_id
);

  localparam logic [CNT_W-1:0] C_MIN = CNT_W'(OVERLAP_MIN);
  localparam logic [CNT_W-1:0] C_MAX = '1;

  logic [CNT_W-1:0] r_cnt [NUM_BALLS+1];
  logic [2:0]       r_hid [NUM_BALLS+1];
  logic [NUM_BALLS:0] r_ballsInGame;
  logic [NUM_BALLS:0] r_collide;
  logic [2:0]         r_currHoleId;

  logic [2:0]         w_holeId;
  logic               w_holeAny;
  logic [NUM_BALLS:0] w_pocketed;
  logic [2:0]         w_colHid;
  logic               w_colAny;

  // Lowest active hole wins; the coloured-ball report takes the lowest pocketed coloured ball.
  always_comb begin
    w_holeId  = '0;
    w_holeAny = |hole_draw_req;
    for (int k = NUM_HOLES - 1; k >= 0; k--) begin
      if (hole_draw_req[k]) w_holeId = 3'(k + 1);
    end
    w_pocketed = '0;
    for (int i = 0; i <= NUM_BALLS; i++) begin
      w_pocketed[i] = r_ballsInGame[i] && (r_cnt[i] >= C_MIN);
    end
    w_colHid = '0;
    w_colAny = 1'b0;
    for (int j = NUM_BALLS; j >= 1; j--) begin
      if (w_pocketed[j]) begin
        w_colHid = r_hid[j];
        w_colAny = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_ballsInGame <= '1;
      r_collide     <= '0;
      r_currHoleId  <= '0;
      for (int i = 0; i <= NUM_BALLS; i++) begin
        r_cnt[i] <= '0;
        r_hid[i] <= '0;
      end
    end else begin
      r_collide <= '0;
      if (rack) begin
        r_ballsInGame <= '1;
        r_currHoleId  <= '0;
        for (int i = 0; i <= NUM_BALLS; i++) begin
          r_cnt[i] <= '0;
          r_hid[i] <= '0;
        end
      end else if (startOfFrame) begin
        r_collide     <= w_pocketed;
        r_ballsInGame <= r_ballsInGame & ~w_pocketed;
        if (w_colAny) r_currHoleId <= w_colHid;
        for (int i = 0; i <= NUM_BALLS; i++) begin
          r_cnt[i] <= '0;
          r_hid[i] <= '0;
        end
      end else begin
        // The first hole touched in a frame owns the ball; counts saturate rather than wrap.
        for (int i = 0; i <= NUM_BALLS; i++) begin
          if (r_ballsInGame[i] && ball_draw_req[i] && w_holeAny) begin
            if (r_cnt[i] == '0) r_hid[i] <= w_holeId;
            if (r_cnt[i] != C_MAX) r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign balls_in_game    = r_ballsInGame;
  assign ballhole_collide = r_collide;
  assign curr_Hole_id     = r_currHoleId;

endmodule

// File: tb/tb_ball_pocket_tracker.sv
// Scoreboard bench for ball_pocket_tracker: stimulus queues hand-computed results,
// a monitor compares them one cycle after every frame/rack event and checks pulses stay single-cycle.
module tb_ball_pocket_tracker;

  typedef struct packed {
    logic [3:0] collide;
    logic [3:0] balls;
    logic [2:0] hid;
  } exp_t;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       rack;
  logic [3:0] ball_draw_req;
  logic [5:0] hole_draw_req;
  logic [3:0] balls_in_game;
  logic [3:0] ballhole_collide;
  logic [2:0] curr_Hole_id;

  logic  tbProbe;
  exp_t  expQ [$];
  string nameQ [$];
  int    checks;
  int    errors;

  ball_pocket_tracker dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .rack            (rack),
    .ball_draw_req   (ball_draw_req),
    .hole_draw_req   (hole_draw_req),
    .balls_in_game   (balls_in_game),
    .ballhole_collide(ballhole_collide),
    .curr_Hole_id    (curr_Hole_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input exp_t e);
    checks++;
    if (ballhole_collide !== e.collide || balls_in_game !== e.balls || curr_Hole_id !== e.hid) begin
      errors++;
      $display("[TB] FAIL %s: got collide=%b balls=%b hid=%0d, expected collide=%b balls=%b hid=%0d",
               name, ballhole_collide, balls_in_game, curr_Hole_id, e.collide, e.balls, e.hid);
    end
  endtask

  // Monitor: one cycle after any frame/rack/probe event pop an expectation, otherwise no pulse allowed.
  initial begin
    logic trig;
    exp_t e;
    string n;
    forever begin
      @(posedge clk);
      trig = startOfFrame | rack | tbProbe;
      @(negedge clk);
      if (!resetN) continue;
      if (trig) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event: got collide=%b with no expectation queued", ballhole_collide);
        end else begin
          e = expQ.pop_front();
          n = nameQ.pop_front();
          checkOutput(n, e);
        end
      end else begin
        checks++;
        if (ballhole_collide !== 4'b0000) begin
          errors++;
          $display("[TB] FAIL stray_pulse: got collide=%b expected 0000", ballhole_collide);
        end
      end
    end
  end

  task automatic pushExp(input string name, input logic [3:0] c, input logic [3:0] b, input logic [2:0] h);
    exp_t e;
    e.collide = c;
    e.balls   = b;
    e.hid     = h;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  // Drive n overlap pixels of one ball against a hole mask.
  task automatic applyStimulus(input int ball, input logic [5:0] mask, input int n);
    for (int p = 0; p < n; p++) begin
      ball_draw_req = 4'(1 << ball);
      hole_draw_req = mask;
      @(posedge clk);
      #1;
    end
    ball_draw_req = '0;
    hole_draw_req = '0;
  endtask

  task automatic pulse(input logic sof, input logic rk, input logic [3:0] bReq, input logic [5:0] hReq,
                       input string name, input logic [3:0] c, input logic [3:0] b, input logic [2:0] h);
    pushExp(name, c, b, h);
    startOfFrame  = sof;
    rack          = rk;
    ball_draw_req = bReq;
    hole_draw_req = hReq;
    @(posedge clk);
    #1;
    startOfFrame  = 1'b0;
    rack          = 1'b0;
    ball_draw_req = '0;
    hole_draw_req = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    resetN = 1'b0;
    startOfFrame = 1'b0;
    rack = 1'b0;
    tbProbe = 1'b0;
    ball_draw_req = '0;
    hole_draw_req = '0;
    repeat (3) @(posedge clk);
    #1;
    resetN = 1'b1;
    pushExp("reset", 4'b0000, 4'b1111, 3'd0);
    tbProbe = 1'b1;
    @(posedge clk);
    #1;
    tbProbe = 1'b0;

    applyStimulus(2, 6'b010000, 70);
    pulse(1, 0, 4'b0100, 6'b000001, "ball2_pocket", 4'b0100, 4'b1011, 3'd5);
    applyStimulus(2, 6'b010000, 70);
    pulse(1, 0, 0, 0, "ball2_out_no_repulse", 4'b0000, 4'b1011, 3'd5);

    applyStimulus(1, 6'b000010, 63);
    pulse(1, 0, 0, 0, "ball1_63px", 4'b0000, 4'b1011, 3'd5);
    applyStimulus(1, 6'b000010, 64);
    pulse(1, 0, 0, 0, "ball1_64px", 4'b0010, 4'b1001, 3'd2);

    pulse(0, 1, 0, 0, "rack_a", 4'b0000, 4'b1111, 3'd0);
    applyStimulus(0, 6'b000001, 100);
    applyStimulus(3, 6'b100000, 100);
    applyStimulus(1, 6'b000100, 80);
    pulse(1, 0, 0, 0, "multi_pocket", 4'b1011, 4'b0100, 3'd3);

    pulse(0, 1, 0, 0, "rack_b", 4'b0000, 4'b1111, 3'd0);
    applyStimulus(1, 6'b000010, 10);
    applyStimulus(1, 6'b001000, 290);
    pulse(1, 0, 0, 0, "saturate_first_hole", 4'b0010, 4'b1101, 3'd2);

    pulse(0, 1, 0, 0, "rack_c", 4'b0000, 4'b1111, 3'd0);
    applyStimulus(2, 6'b110100, 70);
    pulse(1, 0, 0, 0, "lowest_hole_wins", 4'b0100, 4'b1011, 3'd3);

    pulse(0, 1, 0, 0, "rack_d", 4'b0000, 4'b1111, 3'd0);
    applyStimulus(3, 6'b100000, 50);
    pulse(0, 1, 0, 0, "rack_midframe", 4'b0000, 4'b1111, 3'd0);
    applyStimulus(3, 6'b100000, 20);
    pulse(1, 0, 0, 0, "after_rack_20px", 4'b0000, 4'b1111, 3'd0);
    applyStimulus(3, 6'b100000, 100);
    pulse(1, 1, 0, 0, "rack_with_sof", 4'b0000, 4'b1111, 3'd0);
    pulse(1, 0, 0, 0, "rack_discards", 4'b0000, 4'b1111, 3'd0);

    applyStimulus(1, 6'b001000, 64);
    pulse(1, 0, 0, 0, "ball1_hole4", 4'b0010, 4'b1101, 3'd4);
    applyStimulus(0, 6'b000001, 64);
    pulse(1, 0, 0, 0, "white_keeps_hid", 4'b0001, 4'b1100, 3'd4);
    applyStimulus(2, 6'b000000, 100);
    pulse(1, 0, 0, 0, "no_hole_no_effect", 4'b0000, 4'b1100, 3'd4);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain: got %0d pending expectations, expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_pocket_tracker.md
Name: ball_pocket_tracker

Overview:
- Sits directly upstream of the game controller state machine. It turns per-pixel overlap between ball sprites and hole sprites into per-frame pocket events.
- Accumulates ball-over-hole pixel counts across each VGA frame and evaluates them at the start of the next frame.
- Drives the three inputs the game controller consumes: `balls_in_game`, `ballhole_collide` (one-cycle pulses) and `curr_Hole_id`.
- Ball 0 is the white (cue) ball; balls 1..NUM_BALLS are coloured.

Parameters:
- NUM_BALLS, 3, index of highest coloured ball; ball vectors are [NUM_BALLS:0].
- NUM_HOLES, 6, number of table holes; hole ids 1..NUM_HOLES, 0 = none.
- OVERLAP_MIN, 64, overlap pixels per frame needed to count a ball as pocketed.
- CNT_W, 8, width of each per-ball overlap counter (saturating).

Ports:
- clk  in  1  system clock (pixel clock domain).
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse at the frame boundary.
- rack  in  1  one-cycle pulse: restore all balls to the table (new game/stage).
- ball_draw_req  in  [NUM_BALLS:0]  per-ball sprite pixel-active for the current pixel.
- hole_draw_req  in  [NUM_HOLES-1:0]  per-hole sprite pixel-active; bit k is hole id k+1.
- balls_in_game  out  [NUM_BALLS:0]  1 = ball still on table.
- ballhole_collide  out  [NUM_BALLS:0]  one-cycle pulse per ball pocketed this evaluation.
- curr_Hole_id  out  3  hole id of most recent coloured-ball pocket; held.

Behaviour:
- Reset (async, resetN=0) values:
  - balls_in_game = all ones.
  - ballhole_collide = 0.
  - curr_Hole_id = 0.
  - All overlap counters = 0; all latched hole ids = 0.
- Per-ball state: cnt[i] (CNT_W bits) and hid[i] (3 bits).
- Accumulate, on any cycle with startOfFrame=0 and rack=0, for each ball i with balls_in_game[i]=1, ball_draw_req[i]=1 and hole_draw_req != 0:
  - cnt[i] increments, saturating at 2^CNT_W-1; no wrap.
  - If cnt[i]==0 before the increment, hid[i] latches the lowest set hole bit index +1. The first hole touched in the frame owns the ball.
  - Multiple hole bits active at once: the lowest index wins.
- Evaluate, on the startOfFrame cycle (rack=0):
  - Pixel inputs on this cycle are ignored.
  - pocketed[i] = balls_in_game[i] & (cnt[i] >= OVERLAP_MIN).
  - Registered at the next edge:
    - ballhole_collide <= pocketed.
    - balls_in_game <= balls_in_game & ~pocketed.
    - curr_Hole_id <= hid[j], where j is the lowest-index coloured ball (1..NUM_BALLS) with pocketed[j]=1. If no coloured ball is pocketed, curr_Hole_id holds.
    - All cnt and hid cleared.
  - Latency: outputs change exactly 1 cycle after the startOfFrame pulse. ballhole_collide is high for exactly 1 cycle, then returns to 0.
- Simultaneous pockets in one frame: all affected bits pulse together. Only the lowest coloured ball's hole is reported. A white-ball pocket (bit 0) never changes curr_Hole_id.
- Balls already out (balls_in_game[i]=0): they never accumulate and never pulse again until rack.
- ball_draw_req with hole_draw_req=0: no effect.
- rack, at any time including mid-frame, takes priority over startOfFrame. Next edge:
  - balls_in_game <= all ones.
  - ballhole_collide <= 0.
  - curr_Hole_id <= 0.
  - cnt and hid cleared.
  - Partial-frame accumulations are discarded.
- Counter saturation: a count at max still compares >= OVERLAP_MIN.
- ballhole_collide is 0 on every cycle other than the one following an evaluation.

Test Plan:
- Reset -> balls_in_game=4'b1111, ballhole_collide=0, curr_Hole_id=0.
- Ball 2 overlaps hole bit 4 (id 5) for 70 pixels, then startOfFrame -> next cycle ballhole_collide=4'b0100 for 1 cycle, balls_in_game=4'b1011, curr_Hole_id=5; a further frame with ball-2 overlap gives no pulse.
- Ball 1 overlaps hole id 2 for 63 pixels, then startOfFrame -> no pulse, balls_in_game unchanged. Next frame 64 pixels -> pulse 4'b0010, curr_Hole_id=2.
- Same frame: white over hole id 1 (100 px), ball 3 over hole id 6 (100 px), ball 1 over hole id 3 (80 px) -> ballhole_collide=4'b1011, curr_Hole_id=3, balls_in_game=4'b0100.
- Ball 1 touches hole id 2 first, then hole id 4; 300 overlap pixels total -> cnt saturates at 255, pocketed, curr_Hole_id=2.
- Ball 3 at 50 overlap pixels, rack mid-frame, then 20 more pixels, startOfFrame -> no pulse, balls_in_game=4'b1111. rack asserted on the same cycle as startOfFrame with pending 100-pixel overlap -> no pulse, curr_Hole_id=0.
